// File: rtl/edid_ddc_ctrl.sv
// edid_ddc_ctrl: DDC/E-DDC sequencer between a byte-level I2C slave PHY and the EDID RAM.
// Define EDID_DDC_WRITE_EN to let the host write EDID bytes after setting the offset.
module edid_ddc_ctrl #(
  parameter logic [6:0] DEV_ADDR     = 7'h50,
  parameter logic [6:0] SEG_ADDR     = 7'h30,
  parameter logic [7:0] RD_IDLE_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ev_start,
  input  logic        ev_stop,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        ack_valid,
  output logic        ack,
  input  logic        tx_req,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [14:0] ram_raddr,
  input  logic [7:0]  ram_rdata,
  output logic        ram_we,
  output logic [14:0] ram_waddr,
  output logic [7:0]  ram_wdata,
  output logic        busy,
  output logic [6:0]  seg_ptr
);
  typedef enum logic [2:0] {IDLE, ADDR, SEG, OFS, WDATA, RD, IGNORE, IGNORE_ACK} state_t;
  state_t state, state_d;
  logic [7:0] ofs_ptr, ofs_d;
  logic [6:0] seg_d;
  logic       ack_d, rx_ok, tx_ok, rd1, rd1_real;
  assign ram_raddr = {seg_ptr, ofs_ptr};
  assign busy = state != IDLE;
  assign rx_ok = rx_valid && !ev_stop && !ev_start && state != IDLE;
  // one read in flight at a time; requests overlapping it are dropped
  assign tx_ok = tx_req && !ev_stop && !ev_start && !rd1 && !tx_valid;
`ifdef EDID_DDC_WRITE_EN
  logic we_d;
`endif
  always_comb begin
    state_d = state;
    seg_d = seg_ptr;
    ofs_d = ofs_ptr;
    ack_d = 1'b0;
`ifdef EDID_DDC_WRITE_EN
    we_d = 1'b0;
`endif
    if (ev_stop) begin
      state_d = IDLE;
      seg_d = '0;
    end else if (ev_start) begin
      state_d = ADDR;
    end else begin
      if (rx_ok)
        case (state)
          ADDR: begin
            ack_d = rx_data == {SEG_ADDR, 1'b0} || rx_data[7:1] == DEV_ADDR;
            state_d = rx_data == {SEG_ADDR, 1'b0} ? SEG :
                      rx_data == {DEV_ADDR, 1'b0} ? OFS :
                      rx_data == {DEV_ADDR, 1'b1} ? RD : IGNORE;
          end
          SEG: begin
            seg_d = rx_data[6:0];
            ack_d = 1'b1;
            state_d = IGNORE_ACK;
          end
          OFS: begin
            ofs_d = rx_data;
            ack_d = 1'b1;
            state_d = WDATA;
          end
          WDATA: begin
`ifdef EDID_DDC_WRITE_EN
            ack_d = 1'b1;
            we_d = 1'b1;
            ofs_d = ofs_ptr + 8'd1;
`else
            state_d = IGNORE;
`endif
          end
          default: ;
        endcase
      if (tx_ok && state == RD) ofs_d = ofs_ptr + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      seg_ptr <= '0;
      ofs_ptr <= '0;
      ack_valid <= 1'b0;
      ack <= 1'b0;
      rd1 <= 1'b0;
      rd1_real <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= '0;
    end else begin
      state <= state_d;
      seg_ptr <= seg_d;
      ofs_ptr <= ofs_d;
      ack_valid <= rx_ok;
      ack <= ack_d;
      rd1 <= tx_ok;
      rd1_real <= tx_ok && state == RD;
      tx_valid <= rd1;
      if (rd1) tx_data <= rd1_real ? ram_rdata : RD_IDLE_BYTE;
    end
`ifdef EDID_DDC_WRITE_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ram_we <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= we_d;
      if (we_d) begin
        ram_waddr <= {seg_ptr, ofs_ptr};
        ram_wdata <= rx_data;
      end
    end
`else
  assign ram_we = 1'b0;
  assign ram_waddr = '0;
  assign ram_wdata = '0;
`endif
endmodule

// File: tb/tb_edid_ddc_ctrl.sv
// tb_edid_ddc_ctrl: directed bench for edid_ddc_ctrl with a behavioural EDID RAM.
module tb_edid_ddc_ctrl;
  logic clk = 0, rst_n = 0, ev_start = 0, ev_stop = 0, rx_valid = 0, tx_req = 0;
  logic [7:0] rx_data = 0, ram_rdata = 0, tx_data, ram_wdata;
  logic ack_valid, ack, tx_valid, ram_we, busy;
  logic [14:0] ram_raddr, ram_waddr;
  logic [6:0] seg_ptr;
  logic [7:0] mem [0:32767];
  int checks = 0, errors = 0;

  edid_ddc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ev_start(ev_start), .ev_stop(ev_stop),
    .rx_valid(rx_valid), .rx_data(rx_data), .ack_valid(ack_valid), .ack(ack),
    .tx_req(tx_req), .tx_valid(tx_valid), .tx_data(tx_data),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .busy(busy), .seg_ptr(seg_ptr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [14:0] a);
    return (a[7:0] + {a[13:8], 2'b00}) ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    ram_rdata <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    ev_start = 1;
    tick();
    ev_start = 0;
  endtask

  task automatic stop();
    ev_stop = 1;
    tick();
    ev_stop = 0;
  endtask

  task automatic send_rx(input logic [7:0] b, output logic av, output logic a, output logic we);
    rx_valid = 1;
    rx_data = b;
    tick();
    rx_valid = 0;
    av = ack_valid;
    a = ack;
    we = ram_we;
  endtask

  task automatic do_read(output logic [14:0] addr, output logic v1, output logic v2, output logic [7:0] d);
    tx_req = 1;
    #1 addr = ram_raddr;
    @(posedge clk);
    #1 tx_req = 0;
    v1 = tx_valid;
    tick();
    v2 = tx_valid;
    d = tx_data;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    checks++; if ({busy, ack_valid, ack, tx_valid, ram_we} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {busy, ack_valid, ack, tx_valid, ram_we}); end
    checks++; if ({seg_ptr, ram_raddr, tx_data} !== 30'h0) begin errors++; $display("FAIL reset_ptrs got seg %h raddr %h txd %h exp 0", seg_ptr, ram_raddr, tx_data); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_idle_rx();
    logic av, a, we;
    send_rx(8'hA0, av, a, we);
    checks++; if (av !== 1'b0) begin errors++; $display("FAIL idle_rx_no_ack got %b exp 0", av); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_read();
    logic av, a, we, v1, v2;
    logic [14:0] addr;
    logic [7:0] d;
    int nv;
    start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy got %b exp 1", busy); end
    send_rx(8'hA0, av, a, we);
    checks++; if ({av, a} !== 2'b11) begin errors++; $display("FAIL read_addr_ack got %b exp 11", {av, a}); end
    send_rx(8'h10, av, a, we);
    checks++; if ({av, a} !== 2'b11) begin errors++; $display("FAIL read_ofs_ack got %b exp 11", {av, a}); end
    start();
    send_rx(8'hA1, av, a, we);
    checks++; if ({av, a} !== 2'b11) begin errors++; $display("FAIL read_rd_ack got %b exp 11", {av, a}); end
    for (int i = 0; i < 3; i++) begin
      do_read(addr, v1, v2, d);
      checks++; if (addr !== 15'h0010 + 15'(i)) begin errors++; $display("FAIL read_addr%0d got %h exp %h", i, addr, 15'h0010 + 15'(i)); end
      checks++; if ({v1, v2} !== 2'b01) begin errors++; $display("FAIL read_timing%0d got %b exp 01", i, {v1, v2}); end
      checks++; if (d !== pat(15'h0010 + 15'(i))) begin errors++; $display("FAIL read_data%0d got %h exp %h", i, d, pat(15'h0010 + 15'(i))); end
    end
    nv = 0;
    tx_req = 1;
    tick();
    tick();
    tx_req = 0;
    for (int i = 0; i < 4; i++) begin
      nv += int'(tx_valid);
      tick();
    end
    checks++; if (nv !== 1) begin errors++; $display("FAIL read_drop_count got %0d exp 1", nv); end
    checks++; if (ram_raddr !== 15'h0014) begin errors++; $display("FAIL read_drop_ptr got %h exp 0014", ram_raddr); end
  endtask

  task automatic test_segment();
    logic av, a, we, v1, v2;
    logic [14:0] addr;
    logic [7:0] d;
    start();
    send_rx(8'h60, av, a, we);
    checks++; if ({av, a} !== 2'b11) begin errors++; $display("FAIL seg_addr_ack got %b exp 11", {av, a}); end
    send_rx(8'h02, av, a, we);
    checks++; if ({av, a, seg_ptr} !== {2'b11, 7'h02}) begin errors++; $display("FAIL seg_set got ack %b seg %h exp 11 02", {av, a}, seg_ptr); end
    send_rx(8'h55, av, a, we);
    checks++; if ({av, a} !== 2'b10) begin errors++; $display("FAIL seg_extra_nack got %b exp 10", {av, a}); end
    start();
    send_rx(8'hA0, av, a, we);
    send_rx(8'h80, av, a, we);
    start();
    send_rx(8'hA1, av, a, we);
    do_read(addr, v1, v2, d);
    checks++; if (addr !== 15'h0280 || d !== pat(15'h0280)) begin errors++; $display("FAIL seg_read got %h/%h exp 0280/%h", addr, d, pat(15'h0280)); end
    stop();
    checks++; if ({busy, seg_ptr} !== 8'h00) begin errors++; $display("FAIL seg_stop got busy %b seg %h exp 0 00", busy, seg_ptr); end
    start();
    send_rx(8'hA1, av, a, we);
    do_read(addr, v1, v2, d);
    checks++; if (addr !== 15'h0081 || d !== pat(15'h0081)) begin errors++; $display("FAIL seg_after_stop got %h/%h exp 0081/%h", addr, d, pat(15'h0081)); end
    stop();
  endtask

  task automatic test_wrap();
    logic av, a, we, v1, v2;
    logic [14:0] addr;
    logic [7:0] d;
    start();
    send_rx(8'h60, av, a, we);
    send_rx(8'h01, av, a, we);
    start();
    send_rx(8'hA0, av, a, we);
    send_rx(8'hFF, av, a, we);
    start();
    send_rx(8'hA1, av, a, we);
    do_read(addr, v1, v2, d);
    checks++; if (addr !== 15'h01FF || d !== pat(15'h01FF)) begin errors++; $display("FAIL wrap_first got %h/%h exp 01FF/%h", addr, d, pat(15'h01FF)); end
    do_read(addr, v1, v2, d);
    checks++; if (addr !== 15'h0100 || d !== pat(15'h0100)) begin errors++; $display("FAIL wrap_second got %h/%h exp 0100/%h", addr, d, pat(15'h0100)); end
    checks++; if (seg_ptr !== 7'h01) begin errors++; $display("FAIL wrap_seg got %h exp 01", seg_ptr); end
    stop();
  endtask

  task automatic test_ignore();
    logic av, a, we, v1, v2;
    logic [14:0] addr;
    logic [7:0] d;
    start();
    send_rx(8'hA4, av, a, we);
    checks++; if ({av, a} !== 2'b10) begin errors++; $display("FAIL ign_wrong_dev got %b exp 10", {av, a}); end
    send_rx(8'h61, av, a, we);
    checks++; if ({av, a, busy} !== 3'b101) begin errors++; $display("FAIL ign_state got %b exp 101", {av, a, busy}); end
    do_read(addr, v1, v2, d);
    checks++; if ({v1, v2, d} !== {2'b01, 8'hFF}) begin errors++; $display("FAIL ign_idle_byte got %b %h exp 01 FF", {v1, v2}, d); end
    checks++; if (ram_raddr !== 15'h0001) begin errors++; $display("FAIL ign_ptr got %h exp 0001", ram_raddr); end
    stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_stop_busy got %b exp 0", busy); end
    start();
    send_rx(8'h61, av, a, we);
    checks++; if ({av, a} !== 2'b10) begin errors++; $display("FAIL seg_read_nack got %b exp 10", {av, a}); end
    stop();
  endtask

  task automatic test_collision();
    logic av, a, we;
    start();
    send_rx(8'hA0, av, a, we);
    ev_stop = 1;
    send_rx(8'h33, av, a, we);
    ev_stop = 0;
    checks++; if ({av, busy} !== 2'b00) begin errors++; $display("FAIL coll_no_ack got %b exp 00", {av, busy}); end
    checks++; if (ram_raddr !== 15'h0001) begin errors++; $display("FAIL coll_ofs got %h exp 0001", ram_raddr); end
  endtask

  task automatic test_reset_mid_read();
    logic av, a, we;
    int nv;
    start();
    send_rx(8'hA1, av, a, we);
    tx_req = 1;
    tick();
    tx_req = 0;
    rst_n = 0;
    #1;
    checks++; if ({busy, ack_valid, ack, tx_valid, ram_we, seg_ptr, ram_raddr, tx_data} !== 35'h0) begin errors++; $display("FAIL midrst_outputs got busy %b txv %b raddr %h txd %h exp 0", busy, tx_valid, ram_raddr, tx_data); end
    tick();
    rst_n = 1;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      nv += int'(tx_valid);
      tick();
    end
    checks++; if (nv !== 0) begin errors++; $display("FAIL midrst_no_txv got %0d exp 0", nv); end
  endtask

  task automatic test_write();
    logic av, a, we;
    logic [3:0] acks, wes;
    start();
    send_rx(8'hA0, av, a, we);
    acks[0] = av & a;
    send_rx(8'h20, av, a, we);
    acks[1] = av & a;
    send_rx(8'h5A, av, a, we);
    acks[2] = av & a;
    wes[2] = we;
    checks++; if (av !== 1'b1) begin errors++; $display("FAIL wr_ack_valid got %b exp 1", av); end
    send_rx(8'hC3, av, a, we);
    acks[3] = av & a;
    wes[3] = we;
    tick();
    stop();
`ifdef EDID_DDC_WRITE_EN
    checks++; if (acks !== 4'b1111 || wes[3:2] !== 2'b11) begin errors++; $display("FAIL wr_acks got %b we %b exp 1111 11", acks, wes[3:2]); end
    checks++; if (mem[15'h0020] !== 8'h5A || mem[15'h0021] !== 8'hC3) begin errors++; $display("FAIL wr_mem got %h %h exp 5A C3", mem[15'h0020], mem[15'h0021]); end
`else
    checks++; if (acks !== 4'b0011 || wes[3:2] !== 2'b00) begin errors++; $display("FAIL wr_acks got %b we %b exp 0011 00", acks, wes[3:2]); end
    checks++; if (mem[15'h0020] !== pat(15'h0020)) begin errors++; $display("FAIL wr_mem got %h exp %h", mem[15'h0020], pat(15'h0020)); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = pat(15'(i));
    test_reset();
    test_idle_rx();
    test_read();
    test_segment();
    test_wrap();
    test_ignore();
    test_collision();
    test_reset_mid_read();
    test_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/edid_ddc_ctrl.md
Name: edid_ddc_ctrl

Overview:
- DDC/E-DDC protocol sequencer between a byte-level I2C slave PHY and the 32 KiB EDID RAM (1-cycle read latency, separate read and write ports).
- Decodes the device address byte, maintains the E-DDC segment pointer (0x30) and the offset pointer (0x50), decides ACK/NACK per byte, and streams RAM bytes to the PHY on read.
- RAM address = {seg_ptr[6:0], ofs_ptr[7:0]}, giving 128 segments × 256 bytes.

Parameters:
- DEV_ADDR, 7'h50, EDID device 7-bit address (offset pointer and data).
- SEG_ADDR, 7'h30, E-DDC segment pointer 7-bit address.
- RD_IDLE_BYTE, 8'hFF, tx_data returned for a tx_req outside a valid read.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ev_start  in  1  1-cycle pulse: START or repeated START detected
- ev_stop  in  1  1-cycle pulse: STOP detected
- rx_valid  in  1  1-cycle pulse: byte received from host
- rx_data  in  8  received byte; first byte after START is {addr[6:0], rnw}
- ack_valid  out  1  1-cycle pulse: ACK decision for last rx byte
- ack  out  1  1 = ACK, 0 = NACK; valid with ack_valid
- tx_req  in  1  1-cycle pulse: PHY needs next read byte
- tx_valid  out  1  1-cycle pulse: tx_data valid
- tx_data  out  8  byte to transmit
- ram_raddr  out  15  RAM read address
- ram_rdata  in  8  RAM read data, valid 1 cycle after ram_raddr is sampled
- ram_we  out  1  RAM write enable (only with the optional feature)
- ram_waddr  out  15  RAM write address
- ram_wdata  out  8  RAM write data
- busy  out  1  high in any state other than IDLE
- seg_ptr  out  7  current segment pointer (status)

Behaviour:
- Reset (async assert, sync release): state IDLE, seg_ptr=0, ofs_ptr=0, ack_valid=0, ack=0, tx_valid=0, tx_data=0, ram_we=0, ram_waddr=0, ram_wdata=0, busy=0.
- ram_raddr = {seg_ptr, ofs_ptr} combinationally at all times.
- States:
  - IDLE: ev_start -> ADDR.
  - ADDR: rx_valid decodes rx_data:
    - {SEG_ADDR,0}: ACK -> SEG.
    - {DEV_ADDR,0}: ACK -> OFS.
    - {DEV_ADDR,1}: ACK -> RD.
    - Anything else, including {SEG_ADDR,1}: NACK -> IGNORE.
  - SEG: rx_valid -> seg_ptr = rx_data[6:0] (bit 7 ignored), ACK -> IGNORE_ACK (waits for START; further bytes NACK).
  - OFS: rx_valid -> ofs_ptr = rx_data, ACK -> WDATA.
  - WDATA: each rx_valid gets NACK (feature off; see Optional Feature) -> IGNORE.
  - RD: tx_req at cycle N -> RAM samples ram_raddr at the end of N; ofs_ptr += 1 at the end of N; tx_data = ram_rdata registered at the end of N+1; tx_valid high in cycle N+2. Host ACK/NACK of read bytes is not visible; reads continue until START or STOP.
  - IGNORE / IGNORE_ACK: all rx_valid NACK; wait for START or STOP.
- Every rx_valid at cycle N produces ack_valid in cycle N+1, in every state except IDLE. In IDLE, rx_valid is ignored with no ack_valid.
- Any state: ev_start -> ADDR (repeated START). seg_ptr is retained; ofs_ptr is retained.
- Any state: ev_stop -> IDLE, seg_ptr cleared to 0 (E-DDC rule). ofs_ptr persists across transactions.
- Offset wrap: ofs_ptr 8'hFF + 1 = 8'h00; seg_ptr is unchanged (no carry into the segment).
- Simultaneous events, priority: ev_stop > ev_start > rx_valid / tx_req. The losing rx_valid gets no ack_valid; the losing tx_req gets no tx_valid and does not advance ofs_ptr.
- ev_stop or ev_start while a read is in flight (cycles N+1..N+2): the pending tx_valid is still issued with the already-fetched data.
- tx_req outside RD: tx_valid in N+2 with tx_data = RD_IDLE_BYTE; pointers unchanged.
- PHY contract: at most one outstanding tx_req. A tx_req arriving while one is in flight is dropped.

Optional Feature:
- Macro EDID_DDC_WRITE_EN.
- Defined: in WDATA each rx_valid gives ACK; ram_we pulses in cycle N+1 with ram_waddr = {seg_ptr, ofs_ptr} (pre-increment) and ram_wdata = rx_data; ofs_ptr += 1 with the same wrap rule. State stays WDATA.
- Undefined: ram_we tied 0, ram_waddr and ram_wdata tied 0; WDATA NACKs as above.

Test Plan:
- Reset, then START, rx 8'hA0, rx 8'h10, repeated START, rx 8'hA1, three tx_req -> ACK, ACK, ACK; ram_raddr 0x0010, 0x0011, 0x0012; tx_data = RAM[0x10..0x12], each tx_valid exactly 2 cycles after its tx_req.
- START, rx 8'h60, rx 8'h02, repeated START, rx 8'hA0, rx 8'h80, repeated START, rx 8'hA1, tx_req -> reads RAM[0x0280]; after STOP, seg_ptr=0, next read from 8'hA1 is at 0x0081.
- Offset set to 8'hFF with seg_ptr=1, two tx_req -> addresses 0x01FF then 0x0100.
- rx 8'hA4 (wrong device), then rx 8'h61 -> NACK each; state IGNORE; tx_req returns 8'hFF; following STOP -> busy=0.
- ev_stop and rx_valid in the same cycle in OFS -> no ack_valid, ofs_ptr unchanged, state IDLE. rst_n asserted mid-read -> all outputs at reset values immediately, no tx_valid after release.
- With EDID_DDC_WRITE_EN: START, rx 8'hA0, 8'h20, 8'h5A, 8'hC3 -> four ACKs; ram_we writes 0x5A@0x0020 and 0xC3@0x0021. Without the macro, the third byte is NACKed and ram_we stays 0.
